seq_sqrt_ahsqr: RTL and testbench

- Parametrised, sequential successor to the combinational AHSQR square-root array.
- Computes an approximate integer square root of a WIDTH-bit unsigned radicand.
- The top K_EXACT bits go through an iterative digit-by-digit (restoring) recurrence, one root bit per clock. The root bits for the truncated low radicand bits are filled by an approximation rule.
- Sits in the Sobel gradient-magnitude path behind the squared-sum stage; valid/ready on both sides.

---
 rtl/seq_sqrt_ahsqr.sv | 159 +++++++++++++++
 tb/tb_seq_sqrt_ahsqr.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_sqrt_ahsqr.sv
// Sequential approximate square root: restoring digit recurrence on
// the top K_EXACT radicand bits, one root bit per clock; the low root
// bits are filled with a midpoint pattern (or 1 for tiny nonzero inputs).
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data
// (WIDTH-bit radicand); out_valid/out_ready/out_root (WIDTH/2 bits),
// out_rem (K_EXACT/2+1 bits, remainder of the exact part).
// Optional macro SQRT_ROUND_EN: round the exact root to nearest
// (saturating) before the result is assembled.
module seq_sqrt_ahsqr #(
    parameter int WIDTH   = 16,
    parameter int K_EXACT = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   out_root,
    output logic [K_EXACT/2:0]   out_rem
);

    localparam int Q_W = WIDTH / 2;
    localparam int F   = (WIDTH - K_EXACT) / 2;
    localparam int N   = K_EXACT / 2;
    localparam int RW  = N + 2;
    localparam int IW  = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_start;
    logic               w_last;

    logic [K_EXACT-1:0] r_sh;
    logic [N-1:0]       r_q;
    logic [RW-1:0]      r_rem;
    logic [IW-1:0]      r_iter;
    logic               r_drop;
    logic [Q_W-1:0]     r_root;
    logic [N:0]         r_orem;

    logic [1:0]         w_d;
    logic [RW:0]        w_acc;
    logic [RW:0]        w_sub;
    logic [RW:0]        w_trial;
    logic               w_ok;
    logic [RW-1:0]      w_rem_n;
    logic [N-1:0]       w_q_n;
    logic [N-1:0]       w_q_f;
    logic [Q_W-1:0]     w_root;
    logic               w_drop_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_start   = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_start = 1'b1;
                    w_next  = S_CALC;
                end
            end
            S_CALC: begin
                if (r_iter == IW'(N - 1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Restoring step. The top rem bit is provably zero; if it were
    // ever set the full-width trial could not go negative.
    assign w_d     = r_sh[K_EXACT-1 -: 2];
    assign w_acc   = {r_rem[RW-2:0], w_d};
    assign w_sub   = {1'b0, r_q, 2'b01};
    assign w_trial = w_acc - w_sub;
    assign w_ok    = ~w_trial[RW] | r_rem[RW-1];
    assign w_rem_n = w_ok ? w_trial[RW-1:0] : w_acc[RW-1:0];
    assign w_q_n   = (r_q << 1) | N'(w_ok);

`ifdef SQRT_ROUND_EN
    assign w_q_f = ((w_rem_n > RW'(w_q_n)) && (w_q_n != '1))
                 ? w_q_n + 1'b1 : w_q_n;
`else
    assign w_q_f = w_q_n;
`endif

    generate
        if (F == 0) begin : g_exact
            assign w_drop_in = 1'b0;
            assign w_root    = Q_W'(w_q_f);
        end else begin : g_approx
            logic [Q_W-1:0] w_qx;
            assign w_drop_in = |in_data[WIDTH-K_EXACT-1:0];
            assign w_qx      = Q_W'(w_q_f);
            assign w_root    = (w_q_f != '0)
                             ? ((w_qx << F) | (Q_W'(1) << (F - 1)))
                             : Q_W'(r_drop);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_q    <= '0;
            r_rem  <= '0;
            r_iter <= '0;
            r_drop <= 1'b0;
            r_root <= '0;
            r_orem <= '0;
        end else if (w_start) begin
            r_sh   <= in_data[WIDTH-1 -: K_EXACT];
            r_drop <= w_drop_in;
            r_q    <= '0;
            r_rem  <= '0;
            r_iter <= '0;
        end else if (r_state == S_CALC) begin
            r_sh   <= r_sh << 2;
            r_q    <= w_q_n;
            r_rem  <= w_rem_n;
            r_iter <= r_iter + 1'b1;
            if (w_last) begin
                r_root <= w_root;
                r_orem <= w_rem_n[N:0];
            end
        end
    end

    assign out_root = r_root;
    assign out_rem  = r_orem;

endmodule

// File: tb/tb_seq_sqrt_ahsqr.sv
// Bench for seq_sqrt_ahsqr: an exact (K=16) and an approximate (K=14)
// instance, checked against an arithmetic model plus literal values.
module tb_seq_sqrt_ahsqr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [15:0] a_id;
    logic [7:0]  a_root;
    logic [8:0]  a_rem;
    logic        b_iv, b_ir, b_ov, b_or;
    logic [15:0] b_id;
    logic [7:0]  b_root;
    logic [7:0]  b_rem;

    seq_sqrt_ahsqr #(.WIDTH(16), .K_EXACT(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or),
        .out_root(a_root), .out_rem(a_rem)
    );

    seq_sqrt_ahsqr #(.WIDTH(16), .K_EXACT(14)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or),
        .out_root(b_root), .out_rem(b_rem)
    );

    int total = 0;
    int bad   = 0;
    int a_pops = 0;
    logic [16:0] qa[$];
    logic [15:0] qb[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic tmo(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic int isqrt(input int v);
        int q = 0;
        while ((q + 1) * (q + 1) <= v) q++;
        return q;
    endfunction

    function automatic logic [7:0] m_root(input logic [15:0] x,
                                          input int k);
        int top, q, r, f, qmax;
        top  = int'(x) >> (16 - k);
        q    = isqrt(top);
        r    = top - q * q;
        qmax = (1 << (k / 2)) - 1;
`ifdef SQRT_ROUND_EN
        if (r > q && q < qmax) q++;
`endif
        f = (16 - k) / 2;
        if (f == 0) return 8'(q);
        if (q != 0) return 8'((q << f) | (1 << (f - 1)));
        return ((int'(x) & ((1 << (16 - k)) - 1)) != 0) ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [15:0] m_rem(input logic [15:0] x,
                                          input int k);
        int top, q;
        top = int'(x) >> (16 - k);
        q   = isqrt(top);
        return 16'(top - q * q);
    endfunction

    // per-cycle compare, channel A (also checks hold under stall)
    initial begin
        logic       p_ov, p_or;
        logic [7:0] p_root;
        logic [8:0] p_rem;
        p_ov = 0; p_or = 0; p_root = 0; p_rem = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ov = 0;
            end else begin
                if (p_ov && !p_or) begin
                    chk("a_hold_valid", a_ov, 1);
                    chk("a_hold_root", a_root, p_root);
                    chk("a_hold_rem", a_rem, p_rem);
                end
                if (a_ov) begin
                    if (qa.size() == 0) begin
                        tmo("a_unexpected_output_no");
                    end else begin
                        chk("a_root_model", a_root, qa[0][16:9]);
                        chk("a_rem_model", a_rem, qa[0][8:0]);
                        if (a_or) begin
                            void'(qa.pop_front());
                            a_pops++;
                        end
                    end
                end
                p_ov = a_ov; p_or = a_or;
                p_root = a_root; p_rem = a_rem;
            end
        end
    end

    // per-cycle compare, channel B
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && b_ov) begin
                if (qb.size() == 0) begin
                    tmo("b_unexpected_output_no");
                end else begin
                    chk("b_root_model", b_root, qb[0][15:8]);
                    chk("b_rem_model", b_rem, qb[0][7:0]);
                    if (b_or) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic send_a(input logic [15:0] x);
        int n = 0;
        @(posedge clk); #1;
        a_iv = 1; a_id = x;
        @(negedge clk);
        while (!a_ir && n < 50) begin @(negedge clk); n++; end
        if (!a_ir) tmo("a_accept");
        @(posedge clk);
        qa.push_back({m_root(x, 16), 9'(m_rem(x, 16))});
        #1 a_iv = 0;
    endtask

    task automatic send_b(input logic [15:0] x);
        int n = 0;
        @(posedge clk); #1;
        b_iv = 1; b_id = x;
        @(negedge clk);
        while (!b_ir && n < 50) begin @(negedge clk); n++; end
        if (!b_ir) tmo("b_accept");
        @(posedge clk);
        qb.push_back({m_root(x, 14), 8'(m_rem(x, 14))});
        #1 b_iv = 0;
    endtask

    task automatic wait_a(input int lat);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_ov && n < 40);
        if (!a_ov) tmo("a_result");
        else chk("a_latency", n, lat);
    endtask

    task automatic wait_b(input int lat);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!b_ov && n < 40);
        if (!b_ov) tmo("b_result");
        else chk("b_latency", n, lat);
    endtask

    task automatic run_a(input logic [15:0] x, input int er, input int em);
        send_a(x);
        wait_a(8);
        chk("a_root_lit", a_root, er);
        chk("a_rem_lit", a_rem, em);
    endtask

    task automatic run_b(input logic [15:0] x, input int er, input int em);
        send_b(x);
        wait_b(7);
        chk("b_root_lit", b_root, er);
        chk("b_rem_lit", b_rem, em);
    endtask

    initial begin
        logic [15:0] v[4];
        time         t_acc[4];
        logic        acc;
        int          i, n, p0;
        rst_n = 0;
        a_iv = 0; a_id = 0; a_or = 1;
        b_iv = 0; b_id = 0; b_or = 1;
        #2;
        chk("rst_a_ready", a_ir, 1);
        chk("rst_a_valid", a_ov, 0);
        chk("rst_a_root", a_root, 0);
        chk("rst_a_rem", a_rem, 0);
        chk("rst_b_ready", b_ir, 1);
        chk("rst_b_valid", b_ov, 0);
        @(posedge clk); #1 rst_n = 1;

        run_a(16'h0000, 0, 0);
        run_a(16'h0090, 12, 0);
        run_a(16'hFFFF, 255, 510);
        run_a(16'h00F0, 15, 15);
`ifdef SQRT_ROUND_EN
        run_a(16'h00F1, 16, 16);
`else
        run_a(16'h00F1, 15, 16);
`endif

        run_b(16'h0190, 21, 0);
        run_b(16'h0003, 1, 0);
        run_b(16'h0000, 0, 0);
        run_b(16'hFFFF, 255, 254);

        // backpressure: 0x1234 = 4660, root 68, rem 36
        a_or = 0;
        send_a(16'h1234);
        wait_a(8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", a_ov, 1);
            chk("bp_ready", a_ir, 0);
            chk("bp_root", a_root, 68);
            chk("bp_rem", a_rem, 36);
            if (k == 1) begin a_iv = 1; a_id = 16'hFFFF; end
            if (k == 2) a_iv = 0;
        end
        a_or = 1;
        @(posedge clk); #1;
        chk("bp_release_ready", a_ir, 1);
        chk("bp_release_valid", a_ov, 0);
        repeat (12) @(posedge clk);

        // back-to-back with in_valid and out_ready held high
        v[0] = 16'h0001; v[1] = 16'h0400;
        v[2] = 16'hF0F0; v[3] = 16'h7FFF;
        p0 = a_pops;
        @(posedge clk); #1;
        a_id = v[0]; a_iv = 1;
        i = 0; n = 0;
        while (i < 4 && n < 200) begin
            @(negedge clk);
            acc = a_ir;
            @(posedge clk);
            n++;
            if (acc) begin
                qa.push_back({m_root(v[i], 16), 9'(m_rem(v[i], 16))});
                t_acc[i] = $time;
                i++;
                #1;
                if (i < 4) a_id = v[i];
                else a_iv = 0;
            end
        end
        if (i < 4) tmo("b2b_accept");
        else begin
            for (int k = 1; k < 4; k++)
                chk("b2b_spacing", 32'(t_acc[k] - t_acc[k-1]), 100);
        end
        n = 0;
        while (a_pops < p0 + 4 && n < 40) begin @(posedge clk); n++; end
        chk("b2b_count", a_pops - p0, 4);

        // reset during iteration 3
        send_a(16'hFFFF);
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_ready", a_ir, 1);
        chk("arst_valid", a_ov, 0);
        chk("arst_root", a_root, 0);
        chk("arst_rem", a_rem, 0);
        qa.delete();
        @(posedge clk); #1 rst_n = 1;
        repeat (15) @(posedge clk);
        run_a(16'h0090, 12, 0);

        repeat (5) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
